// File: rtl/rx_axis_packetizer_if.sv
// AXI-Stream bundle carrying the packetizer output (tvalid/tready/tdata/tlast).
// The master modport is the side that drives data; the slave drives tready.
interface rx_axis_packetizer_if #(
  parameter int DW = 32
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rx_axis_packetizer.sv
// rx_axis_packetizer: buffers a valid-only capture word stream in a FIFO and
// emits AXI-Stream packets of pkt_len words, with tlast on the final word.
// Words arriving on a full FIFO are dropped and counted (drop_cnt, overflow).
// Optional macro RX_PKT_TIMEOUT_EN: closes a partial packet after timeout_cyc
// idle cycles; without it timeout_cyc is ignored and no idle counter exists.
module rx_axis_packetizer #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic [CW-1:0]        pkt_len,
  input  logic [CW-1:0]        timeout_cyc,
  rx_axis_packetizer_if.master m_axis,
  output logic [31:0]          drop_cnt,
  output logic [31:0]          pkt_cnt,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // hold register empty
    HOLD = 2'd1,  // word held, deciding whether/how to present it
    SEND = 2'd2   // word presented on the stream, waiting for tready
  } state_t;

  state_t state, state_n;

  // ---------------------------------------------------------------- FIFO
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          wr_en, drop, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Fullness is taken before any same-cycle pop, so a write on full drops.
  assign wr_en      = enable && in_valid && !fifo_full;
  assign drop       = enable && in_valid && fifo_full;

  // Store incoming words.
  // NOTE: the storage array has no reset; only the pointers define its
  // contents, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Advance FIFO pointers; reset empties the FIFO.
  // NOTE: state is always updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // --------------------------------------------------------- hold stage
  logic [DW-1:0] hold_data;
  logic          tlast_q, tlast_n;
  logic [CW-1:0] idx, idx_n;
  logic [CW-1:0] len_q, len_eff;
  logic          last_word, tmo_hit, load_cfg, pkt_done;

  assign len_eff   = (pkt_len == '0) ? CW'(1) : pkt_len;
  assign last_word = (idx == len_q - CW'(1));
  // Configuration is captured only when the first word of a packet loads.
  assign load_cfg  = pop && (idx_n == '0);
  assign pkt_done  = (state == SEND) && m_axis.tready && tlast_q;

`ifdef RX_PKT_TIMEOUT_EN
  logic [CW-1:0] tmo_q, idle_cnt;

  // Latch the timeout per packet; count empty-FIFO cycles spent in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q    <= '0;
      idle_cnt <= '0;
    end else begin
      if (load_cfg) tmo_q <= timeout_cyc;
      // Cleared everywhere outside HOLD, so every entry into HOLD starts at 0.
      if (state != HOLD)   idle_cnt <= '0;
      else if (fifo_empty) idle_cnt <= idle_cnt + CW'(1);
    end
  end

  assign tmo_hit = (tmo_q != '0) &&
                   (({1'b0, idle_cnt} + (CW+1)'(1)) >= {1'b0, tmo_q});
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cyc;
  assign tmo_hit        = 1'b0;
`endif

  // Next-state, pop and tlast/index decisions.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tlast_n = tlast_q;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (last_word) begin
          state_n = SEND;
          tlast_n = 1'b1;
        end else if (!fifo_empty) begin
          state_n = SEND;
          tlast_n = 1'b0;
        end else if (tmo_hit) begin
          state_n = SEND;
          tlast_n = 1'b1;
        end
      end
      SEND: begin
        if (m_axis.tready) begin
          tlast_n = 1'b0;
          idx_n   = tlast_q ? '0 : idx + CW'(1);
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = HOLD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, hold register, word index and packet length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= '0;
      tlast_q   <= 1'b0;
      idx       <= '0;
      len_q     <= CW'(1);
    end else begin
      state   <= state_n;
      tlast_q <= tlast_n;
      idx     <= idx_n;
      if (pop)      hold_data <= mem[rd_ptr[AW-1:0]];
      if (load_cfg) len_q     <= len_eff;
    end
  end

  // Drop counter (saturating), sticky overflow and packet counter (wrapping).
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      pkt_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 32'd1;
      if (drop)                     overflow <= 1'b1;
      if (pkt_done)                 pkt_cnt  <= pkt_cnt + 32'd1;
    end
  end

  assign m_axis.tvalid = (state == SEND);
  assign m_axis.tdata  = hold_data;
  assign m_axis.tlast  = tlast_q;

endmodule
